// File: rtl/im_fetch_pkg.sv
// Shared encodings and defaults for the instruction-fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package im_fetch_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DBG   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/npc_calc.sv
// Next-PC mux: PC+4, taken branch, j/jal region jump, or jr register target.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is registered.
module npc_calc
  import im_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  // choose the next PC source; jr targets are forced word-aligned
  always_comb begin
    npc = pc_plus4;
    unique case (npc_sel_e'(npc_sel))
      NPC_PC4: npc = pc_plus4;
      NPC_BR:  npc = br_taken ? br_target : pc_plus4;
      NPC_J:   npc = {pc[31:28], imm26, 2'b00};
      NPC_JR:  npc = rs_val & 32'hFFFF_FFFC;
    endcase
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// PC owner and IM port arbiter (core fetch vs debug readback); optional IM_FETCH_CNT_EN adds fetch_cnt.
// Latency: fetch is combinational from pc; debug data returns with dbg_ack one cycle after the DBG cycle.
// Backpressure: stall holds pc; debug requests wait until stall or HALT/FAULT frees the IM port.
module im_fetch_ctrl
  import im_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt_req,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        dbg_req,
  input  logic [9:0]  dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        halted,
  output logic        fault
`ifdef IM_FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [31:0] pc_q, pc_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] npc;
  logic [31:0] pc_off;
  logic        pc_ok;

  npc_calc u_npc_calc (
    .pc       (pc_q),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_val   (rs_val),
    .npc      (npc)
  );

  // byte offset from the IM base; wrap makes below-base PCs look huge
  assign pc_off      = pc_q - PC_RESET;
  assign pc_ok       = (pc_off < IM_BYTES) && (pc_q[1:0] == 2'b00);
  assign im_addr     = (state_q == ST_DBG) ? dbg_addr : pc_off[11:2];
  assign instr_valid = (state_q == ST_RUN) && pc_ok;
  assign instr       = instr_valid ? im_rdata : 32'd0;
  assign pc          = pc_q;
  assign dbg_ack     = dbg_ack_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

  // next-state: fault beats halt, halt beats debug, debug only when fetch is idle
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    pc_d        = pc_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    unique case (state_q)
      ST_RUN: begin
        if (!pc_ok) begin
          state_d  = ST_FAULT;
          fault_d  = 1'b1;
          halted_d = 1'b1;
        end else if (halt_req) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (stall) begin
          if (dbg_req) begin
            state_d = ST_DBG;
            ret_d   = ST_RUN;
          end
        end else begin
          pc_d = npc;
        end
      end
      ST_DBG: begin
        state_d     = ret_q;
        dbg_ack_d   = 1'b1;
        dbg_rdata_d = im_rdata;
      end
      ST_HALT, ST_FAULT: begin
        if (dbg_req) begin
          state_d = ST_DBG;
          ret_d   = state_q;
        end
      end
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      pc_q        <= PC_RESET;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= 32'd0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      pc_q        <= pc_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
    end
  end

`ifdef IM_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // count consumed fetches, saturating at all-ones
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if ((state_q == ST_RUN) && !stall && instr_valid && (fetch_cnt_q != 32'hFFFF_FFFF))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  // fetch counter register
  always_ff @(posedge clk) begin
    if (!reset) fetch_cnt_q <= 32'd0;
    else        fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Randomized scoreboard bench for im_fetch_ctrl against a behavioural fetch model.
// Latency: expectations are queued per cycle and popped by a monitor on the falling edge.
// Backpressure: the bench plays the debug requester, dropping dbg_req once acked.
module tb_im_fetch_ctrl;

  localparam int M_RUN = 0, M_DBG = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] imm26 = 26'd0;
  logic [31:0] rs_val = 32'd0;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        dbg_req = 1'b0;
  logic [9:0]  dbg_addr = 10'd0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        halted;
  logic        fault;
`ifdef IM_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  logic [31:0] mem [0:1023];
  assign im_rdata = mem[im_addr];

  always #5 clk = ~clk;

  im_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt_req    (halt_req),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .imm26       (imm26),
    .rs_val      (rs_val),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .halted      (halted),
    .fault       (fault)
`ifdef IM_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        iv;
    logic [31:0] instr;
    logic        halted;
    logic        fault;
    logic        ack;
    logic        chk_addr;
    logic [9:0]  addr;
    logic        rd_zero;
    logic [31:0] cnt;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] dbg_q[$];
  int          total = 0;
  int          bad = 0;

  // behavioural model state (starts as "just reset": reset is low at the first edge)
  logic [31:0] m_pc = 32'h3000;
  int          m_mode = M_RUN;
  int          m_ret = M_RUN;
  logic        m_ack = 1'b0;
  logic        m_rd_zero = 1'b1;
  logic [31:0] m_cnt = 32'd0;

  function automatic logic legal(input logic [31:0] p);
    return (p >= 32'h3000) && (p < 32'h4000) && (p % 4 == 0);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] p);
    return (p - 32'h3000) / 4;
  endfunction

  function automatic logic [31:0] target(input logic [31:0] p);
    case (npc_sel)
      2'd1:    return br_taken ? p + 32'd4 + 32'($signed(imm16)) * 32'd4 : p + 32'd4;
      2'd2:    return (p & 32'hF000_0000) + 32'(imm26) * 32'd4;
      2'd3:    return rs_val - (rs_val % 4);
      default: return p + 32'd4;
    endcase
  endfunction

  // record this cycle's expected outputs, then advance the model across the edge
  task automatic step();
    exp_t        e;
    logic [31:0] w;
    logic        next_ack;
    if (m_ack) dbg_req = 1'b0;
    w          = word_of(m_pc);
    e.pc       = m_pc;
    e.iv       = (m_mode == M_RUN) && legal(m_pc);
    e.instr    = e.iv ? mem[w[9:0]] : 32'd0;
    e.halted   = (m_mode == M_HALT) || (m_mode == M_FAULT) || (m_mode == M_DBG && m_ret != M_RUN);
    e.fault    = (m_mode == M_FAULT) || (m_mode == M_DBG && m_ret == M_FAULT);
    e.ack      = m_ack;
    e.chk_addr = (m_mode == M_RUN) || (m_mode == M_DBG);
    e.addr     = (m_mode == M_DBG) ? dbg_addr : w[9:0];
    e.rd_zero  = m_rd_zero;
    e.cnt      = m_cnt;
    cyc_q.push_back(e);

    if (!reset) begin
      if (m_mode == M_DBG) void'(dbg_q.pop_back());
      m_pc = 32'h3000; m_mode = M_RUN; m_ret = M_RUN;
      m_ack = 1'b0; m_rd_zero = 1'b1; m_cnt = 32'd0;
    end else begin
      next_ack = (m_mode == M_DBG);
      if (m_mode == M_RUN && !stall && e.iv && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      case (m_mode)
        M_RUN: begin
          if (!legal(m_pc)) m_mode = M_FAULT;
          else if (halt_req) m_mode = M_HALT;
          else if (stall) begin
            if (dbg_req) begin
              m_ret = M_RUN; m_mode = M_DBG; dbg_q.push_back(mem[dbg_addr]);
            end
          end else m_pc = target(m_pc);
        end
        M_DBG: begin
          m_mode = m_ret; m_rd_zero = 1'b0;
        end
        default: begin
          if (dbg_req) begin
            m_ret = m_mode; m_mode = M_DBG; dbg_q.push_back(mem[dbg_addr]);
          end
        end
      endcase
      m_ack = next_ack;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare each cycle's outputs and every debug acknowledge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("pc", pc, e.pc);
        chk("instr_valid", 32'(instr_valid), 32'(e.iv));
        chk("instr", instr, e.instr);
        chk("halted", 32'(halted), 32'(e.halted));
        chk("fault", 32'(fault), 32'(e.fault));
        chk("dbg_ack", 32'(dbg_ack), 32'(e.ack));
        if (e.chk_addr) chk("im_addr", 32'(im_addr), 32'(e.addr));
        if (e.rd_zero) chk("dbg_rdata_rst", dbg_rdata, 32'd0);
`ifdef IM_FETCH_CNT_EN
        chk("fetch_cnt", fetch_cnt, e.cnt);
`endif
      end
      if (dbg_ack === 1'b1) begin
        if (dbg_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dbg_unexpected: got ack with data %h want no ack", dbg_rdata);
        end else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  initial begin
    int stuck;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    // reset, then sequential fetch
    step();
    reset = 1'b1;
    repeat (4) step();
    // branch back, jump, jump-register
    npc_sel = 2'd1; br_taken = 1'b1; imm16 = 16'hFFFE; step();
    npc_sel = 2'd2; imm26 = 26'h0000C10; step();
    npc_sel = 2'd3; rs_val = 32'h3100; step();
    npc_sel = 2'd0; br_taken = 1'b0;
    // debug read during stall, then held request while fetching
    stall = 1'b1; dbg_req = 1'b1; dbg_addr = 10'd5; repeat (3) step();
    stall = 1'b0; dbg_req = 1'b1; repeat (3) step();
    stall = 1'b1; repeat (3) step();
    stall = 1'b0;
    // out-of-range jr, fault, debug in fault
    npc_sel = 2'd3; rs_val = 32'h4000; step();
    npc_sel = 2'd0; repeat (2) step();
    dbg_req = 1'b1; dbg_addr = 10'd7; repeat (3) step();
    reset = 1'b0; step(); reset = 1'b1;
    // halt during stall, pc frozen until reset
    stall = 1'b1; halt_req = 1'b1; step();
    stall = 1'b0; halt_req = 1'b0; repeat (2) step();
    reset = 1'b0; step(); reset = 1'b1;
    // fetches interleaved with stalls
    repeat (5) step();
    stall = 1'b1; repeat (2) step();
    stall = 1'b0; repeat (5) step();

    // randomized phase
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      stuck    = (m_mode == M_HALT || m_mode == M_FAULT) ? stuck + 1 : 0;
      reset    = !(stuck > 15 || $urandom_range(0, 149) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 249) == 0);
      npc_sel  = 2'($urandom_range(0, 3));
      br_taken = 1'($urandom);
      imm16    = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 32)) - 16);
      imm26    = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'(32'h0C00 + $urandom_range(0, 1023));
      rs_val   = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + $urandom_range(0, 4095);
      if (!dbg_req && !m_ack && $urandom_range(0, 5) == 0) begin
        dbg_req  = 1'b1;
        dbg_addr = 10'($urandom);
      end
      step();
    end

    // drain outstanding debug work
    reset = 1'b1; stall = 1'b1; halt_req = 1'b0;
    repeat (4) step();
    repeat (2) @(negedge clk);
    #1;
    chk("dbg_drain", 32'(dbg_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the PC and drives the 1024x32 asynchronous-read instruction memory.
- Selects the next PC from PC+4, branch, jump or jump-register.
- Handles stall, halt and out-of-range fault.
- Arbitrates the single IM read port between core fetch and a debug readback requester. Sits between the CPU control/datapath and the instruction memory.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; also the IM base address.
- IM_WORDS, 1024, IM depth in words; legal PC range is [PC_RESET, PC_RESET+4*IM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- halt_req  in  1  enter HALT at next edge.
- npc_sel  in  2  0=PC+4, 1=branch, 2=j/jal, 3=jr.
- br_taken  in  1  branch condition; meaningful only when npc_sel=1.
- imm16  in  16  branch offset.
- imm26  in  26  jump index.
- rs_val  in  32  jr target.
- im_addr  out  10  IM word address.
- im_rdata  in  32  IM read data (combinational).
- pc  out  32  current PC.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr is valid this cycle.
- dbg_req  in  1  debug read request; held until acknowledged.
- dbg_addr  in  10  debug word address.
- dbg_ack  out  1  one-cycle acknowledge.
- dbg_rdata  out  32  debug data, valid with dbg_ack.
- halted  out  1  in HALT or FAULT.
- fault  out  1  PC out of range.

Behaviour:
- Reset (reset=0 at edge):
  - pc=PC_RESET; state=RUN.
  - dbg_ack=0, dbg_rdata=0, fault=0, halted=0.
  - Reset mid debug transaction drops it without an ack.
- States: RUN, DBG, HALT, FAULT.
- Fetch ownership:
  - In RUN with stall=0: im_addr = pc[11:2] - PC_RESET[11:2] (i.e. (pc-PC_RESET)>>2 truncated to 10 bits).
  - instr=im_rdata; instr_valid=1 when RUN and the PC is in range; otherwise instr=0, instr_valid=0.
- Next PC (RUN, stall=0), registered at the edge:
  - npc_sel 0: pc+4.
  - npc_sel 1: br_taken ? pc+4+(sext(imm16)<<2) : pc+4.
  - npc_sel 2: {pc[31:28], imm26, 2'b00}.
  - npc_sel 3: rs_val.
  - All 32-bit wrap arithmetic. rs_val[1:0] is ignored (forced to 00).
- Stall: pc holds; instr_valid stays 1 (same instr).
- Arbitration:
  - Fetch has priority in RUN with stall=0; a pending dbg_req waits.
  - When dbg_req=1 and (stall=1 or state is HALT/FAULT): state goes to DBG for exactly one cycle.
  - In DBG: im_addr=dbg_addr; dbg_rdata is registered from im_rdata and dbg_ack=1 in the following cycle.
  - DBG returns to its entry state (RUN/HALT/FAULT); pc is unchanged during DBG.
  - Requester must drop dbg_req the cycle after ack; if it is still high, a new transaction starts.
- halt_req:
  - RUN->HALT at the edge, with priority over next-PC update; pc is frozen.
  - HALT is left only by reset. halted=1 in HALT.
- Fault:
  - If the registered pc is outside the legal range or misaligned (pc[1:0]!=0), the next edge enters FAULT.
  - In FAULT: fault=1, halted=1, instr_valid=0; pc retains the offending value.
- Simultaneous events:
  - halt_req + stall: HALT.
  - halt_req + fault condition: FAULT wins.
  - dbg_req in RUN with stall=0: no grant.

Optional Feature:
- IM_FETCH_CNT_EN: adds output fetch_cnt[31:0].
  - Reset 0; increments on each RUN cycle with stall=0 and instr_valid=1; saturates at 32'hFFFF_FFFF.
- Without the macro: no port, no counter logic.

Decomposition:
- Package im_fetch_pkg holds:
  - NPC_PC4/NPC_BR/NPC_J/NPC_JR encodings.
  - State encodings ST_RUN/ST_DBG/ST_HALT/ST_FAULT.
  - PC_RESET default.
- One sub-module: npc_calc, the combinational next-PC mux and adders.

Test Plan:
- Reset, then 3 cycles npc_sel=0, no stall -> pc 0x3000, 0x3004, 0x3008, 0x300C; im_addr 0,1,2,3.
- At pc=0x3010: npc_sel=1, br_taken=1, imm16=0xFFFE -> pc=0x300C. Then npc_sel=2, imm26=0x0000C10 -> pc=0x3040. Then npc_sel=3, rs_val=0x3100 -> pc=0x3100.
- stall=1 with dbg_req=1, dbg_addr=5, IM[5]=0xDEADBEEF -> DBG one cycle, dbg_ack=1 with dbg_rdata=0xDEADBEEF next cycle, pc unchanged. Same request with stall=0 -> no ack until stall rises.
- npc_sel=3, rs_val=0x4000 (out of range) -> next edge fault=1, halted=1, instr_valid=0. Debug read still served.
- halt_req during stall -> HALT, pc frozen. Pulse reset=0 -> pc=0x3000, halted=0.
- With IM_FETCH_CNT_EN: 10 fetches with 2 stall cycles in between -> fetch_cnt=10.
